// File: rtl/modbus_rtu_framer_pkg.sv
// ============================================================================
// modbus_rtu_framer_pkg : framer state encoding and the CRC16-Modbus byte step
// Revision 1.0
// ============================================================================
`default_nettype none

package modbus_rtu_framer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SIL   = 3'd1,
      ST_ADDR  = 3'd2,
      ST_PDU   = 3'd3,
      ST_CRCL  = 3'd4,
      ST_CRCH  = 3'd5,
      ST_DRAIN = 3'd6
   } state_t;

   localparam logic [15:0] MODBUS_CRC_INIT = 16'hFFFF;
   localparam logic [15:0] MODBUS_CRC_POLY = 16'hA001;

   // Reflected CRC: fold the byte into the low end, then shift out 8 bits LSB first.
   function automatic logic [15:0] crc16_modbus_byte(input logic [15:0] crc, input logic [7:0] data);
      logic [15:0] c;
      c = crc ^ {8'h00, data};
      for (int i = 0; i < 8; i++) begin
         c = c[0] ? ((c >> 1) ^ MODBUS_CRC_POLY) : (c >> 1);
      end
      return c;
   endfunction

endpackage

`default_nettype wire

// File: rtl/crc16_modbus_acc.sv
// ============================================================================
// crc16_modbus_acc : registered CRC16-Modbus accumulator, one byte per enable
// Revision 1.0
// ============================================================================
`default_nettype none

module crc16_modbus_acc
   import modbus_rtu_framer_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        init,
   input  logic        en,
   input  logic [7:0]  data,
   output logic [15:0] crc
);

   always_ff @(posedge clk) begin
      if (rst || init) begin
         crc <= MODBUS_CRC_INIT;
      end else if (en) begin
         crc <= crc16_modbus_byte(crc, data);
      end
   end

endmodule

`default_nettype wire

// File: rtl/modbus_rtu_framer.sv
// ============================================================================
// modbus_rtu_framer : TX Modbus RTU framer (silence, ADDR, PDU, CRC16 low/high)
// Revision 1.0
// ============================================================================
`default_nettype none

module modbus_rtu_framer
   import modbus_rtu_framer_pkg::*;
#(
   parameter int MAX_PDU = 253,
   parameter int SIL_W   = 24
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [SIL_W-1:0] sil_cycles,
   input  logic             tx_idle,
   input  logic             req_v,
   input  logic [7:0]       req_addr,
   output logic             req_rdy,
   input  logic [7:0]       pdu_data,
   input  logic             pdu_valid,
   input  logic             pdu_last,
   output logic             pdu_ready,
   output logic [7:0]       tx_b,
   output logic             tx_b_v,
   input  logic             tx_b_rdy,
   output logic             busy,
   output logic             frame_done,
   output logic [7:0]       pdu_len,
   output logic             err_ovf
);

   localparam logic [7:0] PDU_LIMIT = 8'(MAX_PDU);

   state_t           state;
   state_t           state_nx;
   logic [SIL_W-1:0] sil_cnt;
   logic [7:0]       addr_q;
   logic             ovf;
   logic [15:0]      crc;
   logic             crc_init;
   logic             crc_en;
   logic             xfer;
   logic             sil_ok;
   logic [7:0]       len_inc;

   assign xfer    = tx_b_v & tx_b_rdy;
   assign sil_ok  = (sil_cnt >= sil_cycles);
   assign len_inc = pdu_len + 8'd1;
   assign busy    = (state != ST_IDLE);

   // Line silence: counts idle cycles, restarts on any byte sent or line activity.
   always_ff @(posedge clk) begin
      if (rst || xfer || !tx_idle) begin
         sil_cnt <= '0;
      end else if (sil_cnt != '1) begin
         sil_cnt <= sil_cnt + SIL_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q  <= 8'h00;
         pdu_len <= 8'h00;
         ovf     <= 1'b0;
      end else begin
         if (state == ST_IDLE && req_v) begin
            addr_q  <= req_addr;
            pdu_len <= 8'h00;
            ovf     <= 1'b0;
         end
         if (state == ST_PDU && xfer) begin
            pdu_len <= len_inc;
            if (!pdu_last && len_inc == PDU_LIMIT) begin
               ovf <= 1'b1;
            end
         end
      end
   end

   crc16_modbus_acc u_crc (
      .clk  (clk),
      .rst  (rst),
      .init (crc_init),
      .en   (crc_en),
      .data (tx_b),
      .crc  (crc)
   );

   always_comb begin
      state_nx   = state;
      req_rdy    = 1'b0;
      pdu_ready  = 1'b0;
      tx_b       = 8'h00;
      tx_b_v     = 1'b0;
      frame_done = 1'b0;
      err_ovf    = 1'b0;
      crc_init   = 1'b0;
      crc_en     = 1'b0;
      case (state)
         ST_IDLE: begin
            req_rdy  = 1'b1;
            crc_init = req_v;
            if (req_v) state_nx = ST_SIL;
         end
         ST_SIL: begin
            if (sil_ok) state_nx = ST_ADDR;
         end
         ST_ADDR: begin
            tx_b   = addr_q;
            tx_b_v = 1'b1;
            if (tx_b_rdy) begin
               crc_en   = 1'b1;
               state_nx = ST_PDU;
            end
         end
         ST_PDU: begin
            tx_b      = pdu_data;
            tx_b_v    = pdu_valid;
            pdu_ready = tx_b_rdy;
            if (xfer) begin
               crc_en = 1'b1;
               if (pdu_last) begin
                  state_nx = ST_CRCL;
               end else if (len_inc == PDU_LIMIT) begin
                  err_ovf  = 1'b1;
                  state_nx = ST_CRCL;
               end
            end
         end
         ST_CRCL: begin
            tx_b   = crc[7:0];
            tx_b_v = 1'b1;
            if (tx_b_rdy) state_nx = ST_CRCH;
         end
         ST_CRCH: begin
            tx_b   = crc[15:8];
            tx_b_v = 1'b1;
            if (tx_b_rdy) begin
               frame_done = 1'b1;
               state_nx   = ovf ? ST_DRAIN : ST_IDLE;
            end
         end
         ST_DRAIN: begin
            // Swallow the rest of an over-long PDU so the next frame starts clean.
            pdu_ready = 1'b1;
            if (pdu_valid && pdu_last) state_nx = ST_IDLE;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

endmodule

`default_nettype wire

// File: tb/tb_modbus_rtu_framer.sv
// ============================================================================
// tb_modbus_rtu_framer : scoreboard bench for the Modbus RTU TX framer
// Revision 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_modbus_rtu_framer;

   localparam int TB_MAX_PDU = 6;
   localparam int TB_SIL_W   = 24;

   logic                clk = 1'b0;
   logic                rst;
   logic [TB_SIL_W-1:0] sil_cycles;
   logic                tx_idle;
   logic                req_v;
   logic [7:0]          req_addr;
   logic                req_rdy;
   logic [7:0]          pdu_data;
   logic                pdu_valid;
   logic                pdu_last;
   logic                pdu_ready;
   logic [7:0]          tx_b;
   logic                tx_b_v;
   logic                tx_b_rdy;
   logic                busy;
   logic                frame_done;
   logic [7:0]          pdu_len;
   logic                err_ovf;

   modbus_rtu_framer #(.MAX_PDU(TB_MAX_PDU), .SIL_W(TB_SIL_W)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .sil_cycles (sil_cycles),
      .tx_idle    (tx_idle),
      .req_v      (req_v),
      .req_addr   (req_addr),
      .req_rdy    (req_rdy),
      .pdu_data   (pdu_data),
      .pdu_valid  (pdu_valid),
      .pdu_last   (pdu_last),
      .pdu_ready  (pdu_ready),
      .tx_b       (tx_b),
      .tx_b_v     (tx_b_v),
      .tx_b_rdy   (tx_b_rdy),
      .busy       (busy),
      .frame_done (frame_done),
      .pdu_len    (pdu_len),
      .err_ovf    (err_ovf)
   );

   always #5 clk = ~clk;

   int         cyc = 0;
   int         n_vec = 0;
   int         n_bad = 0;
   int         last_xfer_cyc = 0;
   logic       prev_stall = 1'b0;
   logic [7:0] prev_b = 8'h00;
   logic [7:0] exp_q[$];

   logic [7:0] pdu_a[$]  = '{8'h03, 8'h00, 8'h00, 8'h00, 8'h0A};
   logic [7:0] wire_a[$] = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h0A, 8'hC5, 8'hCD};
   logic [7:0] pdu_b[$]  = '{8'h05, 8'h00, 8'hAC, 8'hFF, 8'h00};
   logic [7:0] wire_b[$] = '{8'h11, 8'h05, 8'h00, 8'hAC, 8'hFF, 8'h00, 8'h4E, 8'h8B};
   logic [7:0] pdu_o[$]  = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'h80};

   task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic push_bytes(input logic [7:0] b[$]);
      foreach (b[i]) exp_q.push_back(b[i]);
   endtask

   function automatic logic [15:0] crc_model(input logic [7:0] b[$]);
      logic [15:0] c;
      c = 16'hFFFF;
      foreach (b[i]) begin
         c = c ^ {8'h00, b[i]};
         for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
      end
      return c;
   endfunction

   // Drives one request and its PDU cycle by cycle; the monitor part pops the
   // scoreboard on every accepted tx_b byte and checks hold-while-stalled.
   task automatic run_frame(input logic [7:0] addr, input logic [7:0] pdu[$],
                            input int rdy_pct, input int gap_pct,
                            input int idle_drop, input int abort_idx,
                            output int acc_cyc, output int v_cyc, output int done_cnt,
                            output int ovf_cnt, output int ovf_idx, output int drop_cyc);
      int   idx, n, t0, guard, stall_n;
      logic fin, consumed, accepted, aborted;
      idx = 0; n = pdu.size(); t0 = cyc; guard = 0; stall_n = 0;
      fin = 1'b0; aborted = 1'b0;
      acc_cyc = -1; v_cyc = -1; done_cnt = 0; ovf_cnt = 0; ovf_idx = -1; drop_cyc = -1;
      req_v = 1'b1; req_addr = addr;
      while (!fin) begin
         tx_b_rdy = ($urandom_range(0, 99) < rdy_pct);
         tx_idle  = 1'b1;
         if (idle_drop >= 0 && cyc - t0 == idle_drop) begin
            tx_idle  = 1'b0;
            drop_cyc = cyc;
         end
         if (idx < n) begin
            if (!pdu_valid) pdu_valid = ($urandom_range(0, 99) >= gap_pct);
            pdu_data = pdu[idx];
            pdu_last = (idx == n - 1);
         end else begin
            pdu_valid = 1'b0; pdu_last = 1'b0; pdu_data = 8'h00;
         end
         if (abort_idx >= 0 && idx == abort_idx && pdu_valid) begin
            tx_b_rdy = 1'b0;
            stall_n++;
            if (stall_n > 15) rst = 1'b1;
         end
         @(negedge clk);
         if (prev_stall) begin
            check_eq("hold_tx_b_v", tx_b_v, 1);
            check_eq("hold_tx_b", tx_b, prev_b);
         end
         prev_stall = tx_b_v && !tx_b_rdy && !rst;
         prev_b     = tx_b;
         if (tx_b_v && v_cyc < 0) v_cyc = cyc;
         if (req_v && req_rdy) acc_cyc = cyc;
         if (tx_b_v && tx_b_rdy) begin
            last_xfer_cyc = cyc;
            if (exp_q.size() == 0) check_eq("unexpected_tx_b_v", tx_b_v, 0);
            else                   check_eq("wire_byte", tx_b, exp_q.pop_front());
         end
         if (frame_done) done_cnt++;
         if (err_ovf) begin
            ovf_cnt++;
            ovf_idx = idx;
         end
         consumed = pdu_valid && pdu_ready;
         accepted = req_v && req_rdy;
         fin = (done_cnt > 0) && ((idx + (consumed ? 1 : 0)) >= n);
         guard++;
         if (!fin && guard > 4000) begin
            check_eq("frame_timeout_done", done_cnt, 1);
            fin = 1'b1;
         end
         tick();
         if (accepted) req_v = 1'b0;
         if (consumed) begin
            idx++;
            pdu_valid = 1'b0;
         end
         if (rst) begin
            rst = 1'b0; fin = 1'b1; aborted = 1'b1;
         end
      end
      req_v = 1'b0; tx_b_rdy = 1'b1; tx_idle = 1'b1;
      if (!aborted) begin
         pdu_valid = 1'b0; pdu_last = 1'b0;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got hang, expected $finish");
      $fatal(1);
   end

   initial begin
      int         acc, vc, dn, ov, oi, dc, rel, lx, rc;
      logic [7:0] ov_bytes[$];
      logic [15:0] ov_crc;

      rst = 1'b1; sil_cycles = 24'd10; tx_idle = 1'b1; req_v = 1'b0; req_addr = 8'h00;
      pdu_data = 8'h00; pdu_valid = 1'b0; pdu_last = 1'b0; tx_b_rdy = 1'b1;
      repeat (3) tick();
      @(negedge clk);
      check_eq("rst_req_rdy", req_rdy, 1);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_tx_b_v", tx_b_v, 0);
      check_eq("rst_tx_b", tx_b, 0);
      check_eq("rst_pdu_ready", pdu_ready, 0);
      check_eq("rst_frame_done", frame_done, 0);
      check_eq("rst_err_ovf", err_ovf, 0);
      check_eq("rst_pdu_len", pdu_len, 0);
      tick();
      rst = 1'b0;
      rel = cyc;

      // Basic frame, full handshake rate, full silence after reset.
      push_bytes(wire_a);
      run_frame(8'h01, pdu_a, 100, 0, -1, -1, acc, vc, dn, ov, oi, dc);
      @(negedge clk);
      check_eq("s1_frame_done_cnt", dn, 1);
      check_eq("s1_err_ovf_cnt", ov, 0);
      check_eq("s1_pdu_len", pdu_len, 5);
      check_eq("s1_bytes_left", exp_q.size(), 0);
      check_eq("s1_busy_after", busy, 0);
      check_eq("s1_sil_after_rst", (vc - rel >= 10) && (vc - rel <= 13), 1);
      tick();

      // Back-to-back request with a 40-cycle silence.
      sil_cycles = 24'd40;
      lx = last_xfer_cyc;
      push_bytes(wire_a);
      run_frame(8'h01, pdu_a, 100, 0, -1, -1, acc, vc, dn, ov, oi, dc);
      check_eq("s2_frame_done_cnt", dn, 1);
      check_eq("s2_sil_gap_ok", (vc - lx >= 40) && (vc - lx <= 43), 1);

      // Line activity during the wait restarts the silence count.
      push_bytes(wire_a);
      run_frame(8'h01, pdu_a, 100, 0, 20, -1, acc, vc, dn, ov, oi, dc);
      check_eq("s2b_frame_done_cnt", dn, 1);
      check_eq("s2b_restart_gap_ok", (dc >= 0) && (vc - dc >= 40) && (vc - dc <= 43), 1);

      // Random back-pressure and PDU gaps.
      sil_cycles = 24'd10;
      for (int r = 0; r < 3; r++) begin
         push_bytes(wire_a);
         run_frame(8'h01, pdu_a, 30, 40, -1, -1, acc, vc, dn, ov, oi, dc);
         @(negedge clk);
         check_eq("s3_frame_done_cnt", dn, 1);
         check_eq("s3_pdu_len", pdu_len, 5);
         check_eq("s3_bytes_left", exp_q.size(), 0);
         tick();
      end

      // Over-long PDU: MAX_PDU bytes sent, rest drained.
      ov_bytes = '{8'h05};
      for (int i = 0; i < TB_MAX_PDU; i++) ov_bytes.push_back(pdu_o[i]);
      ov_crc = crc_model(ov_bytes);
      push_bytes(ov_bytes);
      exp_q.push_back(ov_crc[7:0]);
      exp_q.push_back(ov_crc[15:8]);
      run_frame(8'h05, pdu_o, 60, 20, -1, -1, acc, vc, dn, ov, oi, dc);
      @(negedge clk);
      check_eq("s4_err_ovf_cnt", ov, 1);
      check_eq("s4_err_ovf_byte_idx", oi, TB_MAX_PDU - 1);
      check_eq("s4_frame_done_cnt", dn, 1);
      check_eq("s4_pdu_len", pdu_len, TB_MAX_PDU);
      check_eq("s4_bytes_left", exp_q.size(), 0);
      check_eq("s4_busy_after_drain", busy, 0);
      tick();

      // Reset while byte 3 is stalled on the wire.
      push_bytes(wire_a);
      run_frame(8'h01, pdu_a, 100, 0, -1, 2, acc, vc, dn, ov, oi, dc);
      rc = cyc;
      @(negedge clk);
      check_eq("s5_busy", busy, 0);
      check_eq("s5_tx_b_v", tx_b_v, 0);
      check_eq("s5_req_rdy", req_rdy, 1);
      check_eq("s5_pdu_len", pdu_len, 0);
      exp_q.delete();
      prev_stall = 1'b0;
      tick();
      pdu_valid = 1'b0; pdu_last = 1'b0;
      push_bytes(wire_a);
      run_frame(8'h01, pdu_a, 100, 0, -1, -1, acc, vc, dn, ov, oi, dc);
      check_eq("s5_next_frame_done", dn, 1);
      check_eq("s5_full_sil_after_rst", (vc - rc >= 10) && (vc - rc <= 13), 1);

      // Zero silence: ADDR two cycles after request accept.
      sil_cycles = 24'd0;
      push_bytes(wire_b);
      run_frame(8'h11, pdu_b, 100, 0, -1, -1, acc, vc, dn, ov, oi, dc);
      @(negedge clk);
      check_eq("s6_addr_latency", vc - acc, 2);
      check_eq("s6_frame_done_cnt", dn, 1);
      check_eq("s6_pdu_len", pdu_len, 5);
      check_eq("s6_bytes_left", exp_q.size(), 0);
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
